// File: rtl/kv_dcache.sv
`default_nettype none
// ============================================================================
// kv_dcache - N-way set-associative, write-back, write-allocate data cache
// Revision: 1.0
// ============================================================================
module kv_dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAY_NUM    = 2,
    parameter int LINE_SIZE  = 4,
    parameter int LINE_NUM   = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH-1:0]   i_load_addr,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    output logic [DATA_WIDTH-1:0]   o_load_data,
    output logic                    o_load_valid,
    input  logic                    i_load_ready,
    input  logic [ADDR_WIDTH-1:0]   i_store_addr,
    input  logic [DATA_WIDTH-1:0]   i_store_data,
    input  logic [DATA_WIDTH/8-1:0] i_store_strb,
    input  logic                    i_store_valid,
    output logic                    o_store_ready,
    output logic [ADDR_WIDTH-1:0]   o_fetch_addr,
    output logic                    o_fetch_valid,
    input  logic                    i_fetch_ready,
    input  logic [DATA_WIDTH-1:0]   i_fetch_data [LINE_SIZE],
    input  logic                    i_fetch_valid,
    output logic                    o_fetch_ready,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [DATA_WIDTH-1:0]   o_wb_data [LINE_SIZE],
    output logic                    o_wb_valid,
    input  logic                    i_wb_ready
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_W    = $clog2(STRB_W);
    localparam int WORD_W   = $clog2(LINE_SIZE);
    localparam int IDX_W    = $clog2(LINE_NUM);
    localparam int LINE_OFF = OFF_W + WORD_W;
    localparam int TAG_W    = ADDR_WIDTH - LINE_OFF - IDX_W;
    localparam int WAY_W    = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        WRITEBACK  = 3'd2,
        FETCH_REQ  = 3'd3,
        FETCH_WAIT = 3'd4,
        RESPOND    = 3'd5
    } state_t;

    state_t state, state_next;

    logic [TAG_W-1:0]      tag_mem  [WAY_NUM][LINE_NUM];
    logic [DATA_WIDTH-1:0] data_mem [WAY_NUM][LINE_NUM][LINE_SIZE];
    logic [LINE_NUM-1:0]   valid    [WAY_NUM];
    logic [LINE_NUM-1:0]   dirty    [WAY_NUM];
    logic [WAY_W-1:0]      rr       [LINE_NUM];

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [STRB_W-1:0]     req_strb;
    logic                  req_store;
    logic [WAY_W-1:0]      victim;
    logic                  victim_fresh;
    logic [DATA_WIDTH-1:0] load_data;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              have_invalid;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  miss_way;
    logic              fill;
    logic              unused_bits;

    assign idx  = req_addr[LINE_OFF +: IDX_W];
    assign tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign word = req_addr[OFF_W +: WORD_W];
    assign unused_bits = ^req_addr[LINE_OFF-1:0];

    // Descending scan so the lowest-index match/invalid way wins.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        have_invalid = 1'b0;
        invalid_way  = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid[w][idx] && (tag_mem[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid[w][idx]) begin
                have_invalid = 1'b1;
                invalid_way  = WAY_W'(w);
            end
        end
    end

    assign miss_way     = have_invalid ? invalid_way : rr[idx];
    assign fill         = (state == FETCH_WAIT) && i_fetch_valid;
    assign o_load_data  = load_data;
    assign o_fetch_addr = {req_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign o_wb_addr    = {tag_mem[victim][idx], idx, {LINE_OFF{1'b0}}};

    always_comb begin
        for (int k = 0; k < LINE_SIZE; k++) begin
            o_wb_data[k] = data_mem[victim][idx][k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        o_load_ready  = 1'b0;
        o_store_ready = 1'b0;
        o_load_valid  = 1'b0;
        o_fetch_valid = 1'b0;
        o_fetch_ready = 1'b0;
        o_wb_valid    = 1'b0;
        unique case (state)
            IDLE: begin
                o_load_ready  = 1'b1;
                o_store_ready = !i_load_valid;
                if (i_load_valid || i_store_valid) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                                            state_next = req_store ? IDLE : RESPOND;
                else if (valid[miss_way][idx] && dirty[miss_way][idx]) state_next = WRITEBACK;
                else                                                state_next = FETCH_REQ;
            end
            WRITEBACK: begin
                o_wb_valid = 1'b1;
                if (i_wb_ready) state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                o_fetch_valid = 1'b1;
                if (i_fetch_ready) state_next = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                o_fetch_ready = 1'b1;
                if (i_fetch_valid) state_next = LOOKUP;
            end
            RESPOND: begin
                o_load_valid = 1'b1;
                if (i_load_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_rst) begin
            o_store_ready = 1'b0;
            o_load_valid  = 1'b0;
            o_fetch_valid = 1'b0;
            o_fetch_ready = 1'b0;
            o_wb_valid    = 1'b0;
        end
    end

    // Line bookkeeping: only valid/dirty/rr need reset, tags are guarded by valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
            for (int s = 0; s < LINE_NUM; s++) begin
                rr[s] <= '0;
            end
        end else begin
            if ((state == LOOKUP) && hit && req_store) begin
                dirty[hit_way][idx] <= 1'b1;
            end
            if (fill) begin
                valid[victim][idx] <= 1'b1;
                dirty[victim][idx] <= 1'b0;
                if (!victim_fresh) begin
                    rr[idx] <= (rr[idx] == WAY_W'(WAY_NUM - 1)) ? '0 : rr[idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE) begin
            if (i_load_valid) begin
                req_addr  <= i_load_addr;
                req_store <= 1'b0;
            end else if (i_store_valid) begin
                req_addr  <= i_store_addr;
                req_data  <= i_store_data;
                req_strb  <= i_store_strb;
                req_store <= 1'b1;
            end
        end
        if ((state == LOOKUP) && hit && !req_store) begin
            load_data <= data_mem[hit_way][idx][word];
        end
        if ((state == LOOKUP) && hit && req_store) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (req_strb[b]) data_mem[hit_way][idx][word][b*8 +: 8] <= req_data[b*8 +: 8];
            end
        end
        if ((state == LOOKUP) && !hit) begin
            victim       <= miss_way;
            victim_fresh <= have_invalid;
        end
        if (fill) begin
            tag_mem[victim][idx] <= tag;
            for (int k = 0; k < LINE_SIZE; k++) begin
                data_mem[victim][idx][k] <= i_fetch_data[k];
            end
        end
    end

endmodule
`default_nettype wire
